// File: rtl/fifo_uart_drain.sv
// ---------------------------------------------------------------------------
// fifo_uart_drain
//
// Read-side sequencer for the 8-bit AD sample FIFO. Pulls one byte at a time
// out of the FIFO, hands it to the UART transmitter with a start/busy
// handshake, waits a programmable gap, and then fetches the next byte. It
// also counts transmitted bytes and completed frames. A frame is closed by a
// transmitted TERM_BYTE.
//
// Handshakes:
//   FIFO : rdreq is a one-cycle pulse. q is valid FIFO_RD_LAT cycles after
//          the cycle in which rdreq is high. rdreq is only raised after
//          empty was seen low.
//   UART : tx_start is a one-cycle pulse. tx_data is stable from tx_start
//          until the byte completes. The byte is complete once tx_busy has
//          been seen high and then low again.
//
// Optional feature (macro CTS_FLOW_EN):
//   When defined, an active-low clear-to-send input cts_n is added. It is
//   synchronised by two flops, and tx_start is held off while it is high.
//   When undefined, the cts_n port does not exist.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   enable            drain enable (level), evaluated in IDLE and CHECK
//   empty, q          FIFO empty flag and read data
//   rdreq             FIFO read request pulse
//   tx_data, tx_start byte to send and start strobe to the UART
//   tx_busy           UART busy while shifting
//   cts_n             clear-to-send, active low (CTS_FLOW_EN only)
//   frame_done        pulse in the DONE cycle of a TERM_BYTE
//   byte_cnt          bytes transmitted (wrapping)
//   frame_cnt         frames transmitted (wrapping)
//   active            high whenever the sequencer is not in IDLE
//   dbg_state         current sequencer state, for observation
// ---------------------------------------------------------------------------
module fifo_uart_drain #(
    parameter logic [15:0] GAP_CYCLES  = 16'd100,
    parameter logic [1:0]  FIFO_RD_LAT = 2'd1,
    parameter logic [7:0]  TERM_BYTE   = 8'h0A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        empty,
    input  logic [7:0]  q,
    output logic        rdreq,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
`ifdef CTS_FLOW_EN
    input  logic        cts_n,
`endif
    output logic        frame_done,
    output logic [15:0] byte_cnt,
    output logic [15:0] frame_cnt,
    output logic        active,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD      = 4'd1,
        S_RD_WAIT = 4'd2,
        S_START   = 4'd3,
        S_BUSY_HI = 4'd4,
        S_BUSY_LO = 4'd5,
        S_DONE    = 4'd6,
        S_GAP     = 4'd7,
        S_CHECK   = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lat_q, lat_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rdreq_q, rdreq_d;
    logic        tx_start_q, tx_start_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        active_q, active_d;
    logic        cts_ok;

`ifdef CTS_FLOW_EN
    // Two-flop synchroniser. Resets to "not clear" so that nothing is sent
    // until the far end has actually asserted clear-to-send.
    logic cts_s1_q, cts_s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cts_s1_q <= 1'b1;
            cts_s2_q <= 1'b1;
        end else begin
            cts_s1_q <= cts_n;
            cts_s2_q <= cts_s1_q;
        end
    end

    assign cts_ok = ~cts_s2_q;
`else
    assign cts_ok = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        gap_d        = gap_q;
        tx_data_d    = tx_data_q;
        byte_cnt_d   = byte_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        rdreq_d      = 1'b0;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        active_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !empty) state_d = S_RD;
            end
            S_RD: begin
                lat_d   = 2'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q == FIFO_RD_LAT - 2'd1) begin
                    tx_data_d = q;
                    lat_d     = 2'd0;
                    state_d   = S_START;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_START: begin
                // The strobe for this state was decided one cycle earlier.
                // The cycle that carries it is the last one spent in START.
                if (tx_start_q) state_d = S_BUSY_HI;
            end
            S_BUSY_HI: begin
                if (tx_busy) state_d = S_BUSY_LO;
            end
            S_BUSY_LO: begin
                if (!tx_busy) state_d = S_DONE;
            end
            S_DONE: begin
                if (GAP_CYCLES == 16'd0) begin
                    state_d = S_CHECK;
                end else begin
                    gap_d   = 16'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_CYCLES - 16'd1) begin
                    gap_d   = 16'd0;
                    state_d = S_CHECK;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_CHECK: begin
                state_d = (enable && !empty) ? S_RD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // All outputs are registered, so each one is computed from the state
        // being entered and lines up with that state's cycle.
        rdreq_d  = (state_d == S_RD);
        active_d = (state_d != S_IDLE);

        // The strobe is issued in a START cycle only if tx_busy was low (and
        // CTS clear) in the previous cycle. After tx_busy falls, tx_start
        // therefore follows one cycle later.
        tx_start_d = (state_d == S_START) && !tx_start_q && !tx_busy && cts_ok;

        // DONE lasts one cycle, so entering DONE marks exactly one byte.
        if (state_d == S_DONE) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
            if (tx_data_q == TERM_BYTE) begin
                frame_cnt_d  = frame_cnt_q + 16'd1;
                frame_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            lat_q        <= 2'd0;
            gap_q        <= 16'd0;
            tx_data_q    <= 8'h00;
            rdreq_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            byte_cnt_q   <= 16'd0;
            frame_cnt_q  <= 16'd0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            gap_q        <= gap_d;
            tx_data_q    <= tx_data_d;
            rdreq_q      <= rdreq_d;
            tx_start_q   <= tx_start_d;
            frame_done_q <= frame_done_d;
            byte_cnt_q   <= byte_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            active_q     <= active_d;
        end
    end

    assign rdreq      = rdreq_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign frame_done = frame_done_q;
    assign byte_cnt   = byte_cnt_q;
    assign frame_cnt  = frame_cnt_q;
    assign active     = active_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// ---------------------------------------------------------------------------
// Bench for fifo_uart_drain with GAP_CYCLES=5 and FIFO_RD_LAT=1.
// A queue-based FIFO model and a 10-cycle UART model are updated on the
// falling edge. A monitor samples #1 after each rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_uart_drain;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_START   = 4'd3;
    localparam logic [3:0] S_BUSY_HI = 4'd4;
    localparam logic [3:0] S_BUSY_LO = 4'd5;
    localparam logic [3:0] S_DONE    = 4'd6;
    localparam logic [3:0] S_GAP     = 4'd7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        empty = 1'b1;
    logic [7:0]  q = 8'h00;
    logic        rdreq;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        frame_done;
    logic [15:0] byte_cnt;
    logic [15:0] frame_cnt;
    logic        active;
    logic [3:0]  dbg_state;
`ifdef CTS_FLOW_EN
    logic        cts_n = 1'b0;
`endif

    logic        uart_busy = 1'b0;
    logic        ext_busy = 1'b0;
    int          uart_cnt = 0;
    assign tx_busy = uart_busy | ext_busy;

    int total = 0;
    int bad = 0;

    // Monitor records.
    int cyc = 0;
    int rd_cnt = 0, st_cnt = 0, fd_cnt = 0, fd_bad = 0;
    int bad_rd = 0, data_bad = 0, gap_seen = 0, sb_err = 0;
    int rd_cyc_q[$];
    int st_cyc_q[$];
    int done_cyc_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];
    logic [7:0] fifo_mem[$];
    logic [7:0] held = 8'h00;
    logic [7:0] exp_b;

    fifo_uart_drain #(
        .GAP_CYCLES (16'd5),
        .FIFO_RD_LAT(2'd1),
        .TERM_BYTE  (8'h0A)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .empty     (empty),
        .q         (q),
        .rdreq     (rdreq),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
`ifdef CTS_FLOW_EN
        .cts_n     (cts_n),
`endif
        .frame_done(frame_done),
        .byte_cnt  (byte_cnt),
        .frame_cnt (frame_cnt),
        .active    (active),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    // FIFO model: data appears one cycle after the rdreq cycle.
    always @(negedge clk) begin
        if (rdreq) begin
            if (fifo_mem.size() != 0) q = fifo_mem.pop_front();
            else q = 8'hEE;
        end
        empty = (fifo_mem.size() == 0);
    end

    // UART model: busy for 10 cycles starting mid tx_start cycle.
    always @(negedge clk) begin
        if (tx_start) uart_cnt = 10;
        else if (uart_cnt > 0) uart_cnt = uart_cnt - 1;
        uart_busy = (uart_cnt != 0);
    end

    // Monitor plus scoreboard against exp_q.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rdreq) begin
            rd_cnt++;
            rd_cyc_q.push_back(cyc);
            if (empty) bad_rd++;
        end
        if (tx_start) begin
            st_cnt++;
            st_cyc_q.push_back(cyc);
            tx_log.push_back(tx_data);
            held = tx_data;
            if (exp_q.size() == 0) sb_err++;
            else begin
                exp_b = exp_q.pop_front();
                if (exp_b !== tx_data) sb_err++;
            end
        end
        if ((dbg_state == S_BUSY_HI || dbg_state == S_BUSY_LO || dbg_state == S_DONE) && tx_data !== held)
            data_bad++;
        if (dbg_state == S_DONE) done_cyc_q.push_back(cyc);
        if (dbg_state == S_GAP) gap_seen++;
        if (frame_done) begin
            fd_cnt++;
            if (dbg_state !== S_DONE || tx_data !== 8'h0A) fd_bad++;
        end
    end

    // Driver tasks.
    task automatic push_byte(input logic [7:0] b);
        fifo_mem.push_back(b);
        exp_q.push_back(b);
        empty = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dbg_state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_st(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (st_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Tests.
    task automatic test_reset;
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rdreq !== 1'b0) begin bad++; $display("FAIL rst_rdreq: got %b want 0", rdreq); end
        total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active: got %b want 0", active); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        total++; if (byte_cnt !== 16'd0) begin bad++; $display("FAIL rst_byte_cnt: got %0d want 0", byte_cnt); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_idle: got %0d want %0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_frame;
        int rd0, st0;
        bit ok;
        rd0 = rd_cnt;
        st0 = st_cnt;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h0D); push_byte(8'h0A);
        enable = 1'b1;
        wait_st(st0 + 4, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL frame_starts_timeout: got %0d want %0d", st_cnt - st0, 4); end
        wait_state(S_IDLE, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL frame_idle_timeout: got state %0d want %0d", dbg_state, S_IDLE); end
        total++; if (rd_cnt - rd0 !== 4) begin bad++; $display("FAIL frame_rdreq_count: got %0d want 4", rd_cnt - rd0); end
        total++; if (st_cnt - st0 !== 4) begin bad++; $display("FAIL frame_start_count: got %0d want 4", st_cnt - st0); end
        if (tx_log.size() >= st0 + 4) begin
            total++; if (tx_log[st0] !== 8'h11) begin bad++; $display("FAIL frame_b0: got %h want 11", tx_log[st0]); end
            total++; if (tx_log[st0+1] !== 8'h22) begin bad++; $display("FAIL frame_b1: got %h want 22", tx_log[st0+1]); end
            total++; if (tx_log[st0+2] !== 8'h0D) begin bad++; $display("FAIL frame_b2: got %h want 0D", tx_log[st0+2]); end
            total++; if (tx_log[st0+3] !== 8'h0A) begin bad++; $display("FAIL frame_b3: got %h want 0A", tx_log[st0+3]); end
        end
        // Expected: rdreq in the RD cycle, RD_WAIT, then tx_start in START.
        if (st_cyc_q.size() > st0 && rd_cyc_q.size() > rd0) begin
            total++;
            if (st_cyc_q[st0] - rd_cyc_q[rd0] !== 2) begin
                bad++; $display("FAIL frame_rd_to_start: got %0d want 2", st_cyc_q[st0] - rd_cyc_q[rd0]);
            end
        end
        total++; if (byte_cnt !== 16'd4) begin bad++; $display("FAIL frame_byte_cnt: got %0d want 4", byte_cnt); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL frame_frame_cnt: got %0d want 1", frame_cnt); end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
        total++; if (fd_bad !== 0) begin bad++; $display("FAIL frame_done_align: got %0d want 0", fd_bad); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL frame_active_end: got %b want 0", active); end
    endtask

    task automatic test_gap;
        int rd0, d0, g0;
        bit ok;
        rd0 = rd_cnt;
        d0  = done_cyc_q.size();
        g0  = gap_seen;
        push_byte(8'h33); push_byte(8'h44);
        enable = 1'b1;
        wait_st(st_cnt + 2, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL gap_starts_timeout: got %0d want 2", rd_cnt - rd0); end
        wait_state(S_IDLE, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL gap_idle_timeout: got state %0d want %0d", dbg_state, S_IDLE); end
        // Five GAP cycles plus the CHECK cycle lie between DONE and the next RD.
        if (rd_cyc_q.size() > rd0 + 1 && done_cyc_q.size() > d0) begin
            total++;
            if (rd_cyc_q[rd0+1] - done_cyc_q[d0] !== 7) begin
                bad++; $display("FAIL gap_done_to_rdreq: got %0d want 7", rd_cyc_q[rd0+1] - done_cyc_q[d0]);
            end
        end
        total++; if (gap_seen - g0 !== 10) begin bad++; $display("FAIL gap_cycles: got %0d want 10", gap_seen - g0); end
        total++; if (byte_cnt !== 16'd6) begin bad++; $display("FAIL gap_byte_cnt: got %0d want 6", byte_cnt); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL gap_frame_cnt: got %0d want 1", frame_cnt); end
        total++; if (bad_rd !== 0) begin bad++; $display("FAIL gap_read_empty: got %0d want 0", bad_rd); end
    endtask

    task automatic test_enable_drop;
        int rd0, st0;
        bit ok;
        rd0 = rd_cnt;
        st0 = st_cnt;
        push_byte(8'h55); push_byte(8'h66); push_byte(8'h77);
        enable = 1'b1;
        wait_st(st0 + 2, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_second_start_timeout: got %0d want 2", st_cnt - st0); end
        enable = 1'b0;
        wait_state(S_IDLE, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_idle_timeout: got state %0d want %0d", dbg_state, S_IDLE); end
        repeat (10) @(negedge clk);
        total++; if (fifo_mem.size() !== 1) begin bad++; $display("FAIL drop_usedw: got %0d want 1", fifo_mem.size()); end
        total++; if (rd_cnt - rd0 !== 2) begin bad++; $display("FAIL drop_rdreq_count: got %0d want 2", rd_cnt - rd0); end
        total++; if (byte_cnt !== 16'd8) begin bad++; $display("FAIL drop_byte_cnt: got %0d want 8", byte_cnt); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL drop_active: got %b want 0", active); end
        enable = 1'b1;
        wait_st(st0 + 3, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_resume_timeout: got %0d want 3", st_cnt - st0); end
        wait_state(S_IDLE, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL drop_resume_idle: got state %0d want %0d", dbg_state, S_IDLE); end
        if (tx_log.size() >= st0 + 3) begin
            total++; if (tx_log[st0+2] !== 8'h77) begin bad++; $display("FAIL drop_third_byte: got %h want 77", tx_log[st0+2]); end
        end
        total++; if (byte_cnt !== 16'd9) begin bad++; $display("FAIL drop_byte_cnt_end: got %0d want 9", byte_cnt); end
    endtask

    task automatic test_busy_hold;
        int st0, rel_cyc, early, unstable;
        bit ok;
        st0 = st_cnt;
        early = 0;
        unstable = 0;
        ext_busy = 1'b1;
        push_byte(8'h88);
        enable = 1'b1;
        wait_state(S_START, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_start_timeout: got state %0d want %0d", dbg_state, S_START); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) early++;
            if (tx_data !== 8'h88) unstable++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL hold_no_start: got %0d want 0", early); end
        total++; if (unstable !== 0) begin bad++; $display("FAIL hold_tx_data_stable: got %0d want 0", unstable); end
        rel_cyc = cyc;
        ext_busy = 1'b0;
        wait_st(st0 + 1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_release_timeout: got %0d want 1", st_cnt - st0); end
        if (st_cyc_q.size() > st0) begin
            total++;
            if (st_cyc_q[st0] - rel_cyc !== 1) begin
                bad++; $display("FAIL hold_start_latency: got %0d want 1", st_cyc_q[st0] - rel_cyc);
            end
        end
        wait_state(S_IDLE, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL hold_idle_timeout: got state %0d want %0d", dbg_state, S_IDLE); end
        total++; if (byte_cnt !== 16'd10) begin bad++; $display("FAIL hold_byte_cnt: got %0d want 10", byte_cnt); end
    endtask

    task automatic test_reset_mid;
        int rd0, st0;
        bit ok;
        push_byte(8'h99); push_byte(8'hAA);
        enable = 1'b1;
        wait_state(S_BUSY_LO, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_busy_lo_timeout: got state %0d want %0d", dbg_state, S_BUSY_LO); end
        // Assert reset between clock edges; outputs must clear at once.
        #2;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rmid_active: got %b want 0", active); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rmid_tx_data: got %h want 00", tx_data); end
        total++; if (byte_cnt !== 16'd0) begin bad++; $display("FAIL rmid_byte_cnt: got %0d want 0", byte_cnt); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rmid_frame_cnt: got %0d want 0", frame_cnt); end
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rmid_state: got %0d want %0d", dbg_state, S_IDLE); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rd0 = rd_cnt;
        st0 = st_cnt;
        repeat (20) @(negedge clk);
        total++; if (rd_cnt - rd0 !== 0) begin bad++; $display("FAIL rmid_no_rdreq: got %0d want 0", rd_cnt - rd0); end
        total++; if (st_cnt - st0 !== 0) begin bad++; $display("FAIL rmid_no_start: got %0d want 0", st_cnt - st0); end
        enable = 1'b1;
        wait_st(st0 + 1, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_resume_timeout: got %0d want 1", st_cnt - st0); end
        wait_state(S_IDLE, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_idle_timeout: got state %0d want %0d", dbg_state, S_IDLE); end
        if (tx_log.size() > st0) begin
            total++; if (tx_log[st0] !== 8'hAA) begin bad++; $display("FAIL rmid_resume_byte: got %h want AA", tx_log[st0]); end
        end
        total++; if (byte_cnt !== 16'd1) begin bad++; $display("FAIL rmid_byte_cnt_end: got %0d want 1", byte_cnt); end
    endtask

`ifdef CTS_FLOW_EN
    task automatic test_cts;
        int st0, rel_cyc;
        bit ok;
        st0 = st_cnt;
        cts_n = 1'b1;
        push_byte(8'hBB);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (st_cnt - st0 !== 0) begin bad++; $display("FAIL cts_no_start: got %0d want 0", st_cnt - st0); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL cts_active_stall: got %b want 1", active); end
        rel_cyc = cyc;
        cts_n = 1'b0;
        wait_st(st0 + 1, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL cts_release_timeout: got %0d want 1", st_cnt - st0); end
        if (st_cyc_q.size() > st0) begin
            total++;
            if (st_cyc_q[st0] - rel_cyc !== 3) begin
                bad++; $display("FAIL cts_start_latency: got %0d want 3", st_cyc_q[st0] - rel_cyc);
            end
        end
        wait_state(S_IDLE, 500, ok);
        total++; if (!ok) begin bad++; $display("FAIL cts_idle_timeout: got state %0d want %0d", dbg_state, S_IDLE); end
        total++; if (byte_cnt !== 16'd2) begin bad++; $display("FAIL cts_byte_cnt: got %0d want 2", byte_cnt); end
    endtask
`endif

    task automatic test_scoreboard;
        total++; if (sb_err !== 0) begin bad++; $display("FAIL sb_byte_order: got %0d errors want 0", sb_err); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        total++; if (data_bad !== 0) begin bad++; $display("FAIL sb_tx_data_hold: got %0d want 0", data_bad); end
        total++; if (bad_rd !== 0) begin bad++; $display("FAIL sb_read_empty: got %0d want 0", bad_rd); end
        total++; if (fd_bad !== 0) begin bad++; $display("FAIL sb_frame_done_align: got %0d want 0", fd_bad); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gap();
        test_enable_drop();
        test_busy_hold();
        test_reset_mid();
`ifdef CTS_FLOW_EN
        test_cts();
`endif
        test_scoreboard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
